// File: rtl/data_mem_mp_if.sv
// Bus bundle for the PE data memory: instruction/strobe inputs and read-port outputs.
interface data_mem_mp_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned INST_W = 32
);
  logic                  wren;
  logic                  rden;
  logic                  inst_v;
  logic [INST_W-1:0]     inst;
  logic [2*DATA_W-1:0]   wdata;
  logic [2*DATA_W-1:0]   rdata0;
  logic [2*DATA_W-1:0]   rdata1;
  logic                  rvalid;
  logic                  busy;

  modport master (
    output wren, rden, inst_v, inst, wdata,
    input  rdata0, rdata1, rvalid, busy
  );

  modport slave (
    input  wren, rden, inst_v, inst, wdata,
    output rdata0, rdata1, rvalid, busy
  );
endinterface

// File: rtl/data_mem_mp.sv
// PE data memory: 1 write / 2 read ports decoded from the instruction word, post-reset clear FSM.
// Optional macro DM_BYPASS_EN: write-first forwarding on same-edge write/read address collision.
module data_mem_mp #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned INST_W   = 32,
  parameter bit          CLEAR_EN = 1'b1
) (
  input logic           clk,
  input logic           rst,
  data_mem_mp_if.slave  bus_io
);
  localparam int unsigned WordW = 2 * DATA_W;
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef logic [WordW-1:0] word_t;
  typedef enum logic {StClear, StReady} state_e;

  state_e              state_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic [ADDR_W-1:0]   raddr0_q, raddr1_q, waddr_q;
  logic                wren_q, rden_q, rvalid_q;
  word_t               rdata0_q, rdata1_q;
  word_t               mem_q [Depth];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  word_t               mem_wdata;
  word_t               rd0, rd1;

  // The clear FSM owns the write port while busy; strobes are already forced off then.
  always_comb begin
    mem_we    = wren_q;
    mem_waddr = waddr_q;
    mem_wdata = bus_io.wdata;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end
    rd0 = mem_q[raddr0_q];
    rd1 = mem_q[raddr1_q];
`ifdef DM_BYPASS_EN
    if (wren_q && (waddr_q == raddr0_q)) rd0 = bus_io.wdata;
    if (wren_q && (waddr_q == raddr1_q)) rd1 = bus_io.wdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR_EN ? StClear : StReady;
      busy_q    <= CLEAR_EN;
      clr_cnt_q <= '0;
      raddr0_q  <= '0;
      raddr1_q  <= '0;
      waddr_q   <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          wren_q    <= 1'b0;
          rden_q    <= 1'b0;
          rvalid_q  <= 1'b0;
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= StReady;
            busy_q  <= 1'b0;
          end
        end
        StReady: begin
          if (bus_io.inst_v) begin
            raddr0_q <= bus_io.inst[ADDR_W-1:0];
            raddr1_q <= bus_io.inst[2*ADDR_W-1:ADDR_W];
            waddr_q  <= bus_io.inst[3*ADDR_W-1:2*ADDR_W];
          end
          wren_q   <= bus_io.wren;
          rden_q   <= bus_io.rden;
          rvalid_q <= rden_q;
          if (rden_q) begin
            rdata0_q <= rd0;
            rdata1_q <= rd1;
          end
        end
        default: state_q <= StReady;
      endcase
    end
  end

  assign bus_io.rdata0 = rdata0_q;
  assign bus_io.rdata1 = rdata1_q;
  assign bus_io.rvalid = rvalid_q;
  assign bus_io.busy   = busy_q;
endmodule

// File: tb/tb_data_mem_mp.sv
// Scoreboard bench for data_mem_mp: stimulus pushes expected reads, a negedge monitor pops them.
module tb_data_mem_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_mp_if #(.DATA_W(16), .ADDR_W(8), .INST_W(32)) bus ();

  data_mem_mp #(.DATA_W(16), .ADDR_W(8), .INST_W(32), .CLEAR_EN(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

`ifdef DM_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    int          due;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rvalid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=1 at cycle %0d expected 0", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.tag, "_d0"}, bus.rdata0, mon_e.d0);
        chk({mon_e.tag, "_d1"}, bus.rdata1, mon_e.d1);
        chk({mon_e.tag, "_lat"}, 32'(cyc), 32'(mon_e.due));
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
      checks++;
      errors++;
      $display("FAIL %s_missing: got no rvalid by cycle %0d expected at %0d",
               sbq[0].tag, cyc, sbq[0].due);
      void'(sbq.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] e0, input logic [31:0] e1, input string tag);
    exp_t e;
    e.d0  = e0;
    e.d1  = e1;
    e.due = cyc + 2;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  // One instruction: strobes in the issue cycle, wdata presented in the following (write) cycle.
  task automatic issue(input bit we, input bit re, input logic [7:0] wa, input logic [7:0] ra0,
                       input logic [7:0] ra1, input logic [31:0] wd, input logic [31:0] e0,
                       input logic [31:0] e1, input string tag);
    bus.wren   = we;
    bus.rden   = re;
    bus.inst_v = 1'b1;
    bus.inst   = {8'h00, wa, ra1, ra0};
    if (re) push(e0, e1, tag);
    tick;
    bus.wren   = 1'b0;
    bus.rden   = 1'b0;
    bus.inst_v = 1'b0;
    bus.wdata  = wd;
    tick;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1 rst = 1'b1;
    bus.wren   = 1'b0;
    bus.rden   = 1'b0;
    bus.inst_v = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rdata0", bus.rdata0, 32'd0);
    chk("rst_rdata1", bus.rdata1, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Counts negedges with busy high; optionally pokes strobes at the 10th busy cycle.
  task automatic count_busy(output int cnt, input bit poke);
    cnt = 0;
    @(negedge clk);
    while (bus.busy && cnt < 2000) begin
      cnt++;
      if (poke && cnt == 10) begin
        bus.inst_v = 1'b1;
        bus.inst   = 32'h0040_4040;
        bus.wren   = 1'b1;
        bus.rden   = 1'b1;
        bus.wdata  = 32'hAAAA_5555;
      end else if (poke && cnt == 12) begin
        bus.inst_v = 1'b0;
        bus.wren   = 1'b0;
        bus.rden   = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.wren   = 1'b0;
    bus.rden   = 1'b0;
    bus.inst_v = 1'b0;
    bus.inst   = '0;
    bus.wdata  = '0;

    // Clear after reset, with strobes poked mid-clear that must be ignored.
    do_reset;
    count_busy(n, 1'b1);
    chk("busy_len", 32'(n), 32'd256);
    tick;
    issue(1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, '0, 32'd0, 32'd0, "t1_read");
    issue(1'b0, 1'b1, 8'h00, 8'h40, 8'h40, '0, 32'd0, 32'd0, "t4_read");

    issue(1'b1, 1'b0, 8'h12, 8'h00, 8'h00, 32'hDEAD_BEEF, '0, '0, "t2_wr");
    issue(1'b0, 1'b1, 8'h00, 8'h12, 8'h12, '0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "t2_read");

    // Same-edge collision on each port in turn.
    issue(1'b1, 1'b0, 8'h05, 8'h00, 8'h00, 32'h1, '0, '0, "t3_wr");
    issue(1'b1, 1'b1, 8'h05, 8'h05, 8'h12, 32'h2, Byp ? 32'h2 : 32'h1, 32'hDEAD_BEEF,
          "t3_coll0");
    issue(1'b0, 1'b1, 8'h00, 8'h05, 8'h05, '0, 32'h2, 32'h2, "t3_reread");
    issue(1'b1, 1'b1, 8'h07, 8'h12, 8'h07, 32'h77, 32'hDEAD_BEEF, Byp ? 32'h77 : 32'h0,
          "t3_coll1");
    issue(1'b0, 1'b1, 8'h00, 8'h07, 8'h05, '0, 32'h77, 32'h2, "t3_reread1");

    // One inst_v, three back-to-back rden pulses reusing the latched addresses.
    issue(1'b1, 1'b0, 8'h30, 8'h00, 8'h00, 32'h1234_5678, '0, '0, "t6_wr");
    bus.inst_v = 1'b1;
    bus.inst   = 32'h0000_3030;
    bus.rden   = 1'b1;
    push(32'h1234_5678, 32'h1234_5678, "t6_rd_a");
    tick;
    bus.inst_v = 1'b0;
    push(32'h1234_5678, 32'h1234_5678, "t6_rd_b");
    tick;
    push(32'h1234_5678, 32'h1234_5678, "t6_rd_c");
    tick;
    bus.rden = 1'b0;
    repeat (3) tick;
    chk("hold_rdata0", bus.rdata0, 32'h1234_5678);
    chk("idle_rvalid", 32'(bus.rvalid), 32'd0);

    // Reset mid-clear restarts the full clear.
    do_reset;
    repeat (100) tick;
    chk("midclear_busy", 32'(bus.busy), 32'd1);
    do_reset;
    count_busy(n, 1'b0);
    chk("busy_len_restart", 32'(n), 32'd256);
    tick;
    issue(1'b0, 1'b1, 8'h00, 8'h12, 8'h30, '0, 32'd0, 32'd0, "t5_read");

    repeat (5) tick;
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
